// File: rtl/sr_stream_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : sr_stream_sequencer_pkg
// Brief  : State encoding and width helper shared by the stream sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package sr_stream_sequencer_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] S_FETCH = 3'd1;
    localparam logic [STATE_W-1:0] S_LOAD  = 3'd2;
    localparam logic [STATE_W-1:0] S_SETUP = 3'd3;
    localparam logic [STATE_W-1:0] S_HIGH  = 3'd4;
    localparam logic [STATE_W-1:0] S_SHIFT = 3'd5;
    localparam logic [STATE_W-1:0] S_LATCH = 3'd6;
    localparam logic [STATE_W-1:0] S_DONE  = 3'd7;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int aw_f(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_register.sv
`default_nettype none
// ============================================================================
// Module : shift_register
// Brief  : Parallel-load, MSB-first shift register; o_done flags the last bit.
// Rev    : 1.0  initial release
// ============================================================================
module shift_register #(
    parameter int NB_REG = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_en,
    input  logic [NB_REG-1:0] i_value,
    output logic              o_data,
    output logic              o_done
);

    localparam int              CW     = $clog2(NB_REG);
    localparam logic [CW-1:0]   C_LAST = CW'(NB_REG - 1);

    logic [NB_REG-1:0] data_q;
    logic [CW-1:0]     cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (i_load) begin
            data_q <= i_value;
            cnt_q  <= '0;
        end else if (i_en) begin
            data_q <= {data_q[NB_REG-2:0], 1'b0};
            if (cnt_q != C_LAST) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign o_data = data_q[NB_REG-1];
    assign o_done = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/sr_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module : sr_stream_sequencer
// Brief  : Fetches N_WORDS words, streams each MSB-first behind a divided
//          serial clock through shift_register, then strobes the latch.
// Rev    : 1.0  initial release
// ============================================================================
module sr_stream_sequencer
    import sr_stream_sequencer_pkg::*;
#(
    parameter int NB_REG  = 32,
    parameter int N_WORDS = 4,
    parameter int CLK_DIV = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic                          i_abort,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [aw_f(N_WORDS)-1:0]      o_word_addr,
    input  logic [NB_REG-1:0]             i_word,
    output logic                          o_sr_load,
    output logic                          o_sr_en,
    output logic [NB_REG-1:0]             o_sr_value,
    input  logic                          i_sr_done,
    output logic                          o_sclk,
    output logic                          o_latch
);

    localparam int            AW          = aw_f(N_WORDS);
    localparam int            CW          = aw_f(CLK_DIV);
    localparam logic [CW-1:0] C_DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [AW-1:0] C_LAST_WORD = AW'(N_WORDS - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic               w_div_end;

    assign w_div_end = (cnt_q == C_DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD:  state_d = S_SETUP;
            S_SETUP: if (w_div_end) state_d = S_HIGH;
            S_HIGH:  if (w_div_end) state_d = S_SHIFT;
            S_SHIFT: begin
                if (!i_sr_done) begin
                    state_d = S_SETUP;
                end else if (idx_q == C_LAST_WORD) begin
                    state_d = S_LATCH;
                end else begin
                    state_d = S_FETCH;
                    idx_d   = idx_q + AW'(1);
                end
            end
            S_LATCH: if (w_div_end) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (i_abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end
    end

    // Divider only runs in the timed states and restarts on any state change.
    always_comb begin
        cnt_d = '0;
        if ((state_q == S_SETUP || state_q == S_HIGH || state_q == S_LATCH) &&
            (state_d == state_q)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Load/shift strobes are suppressed under abort so the shift register keeps its contents.
    always_comb begin
        o_busy    = (state_q != S_IDLE);
        o_done    = 1'b0;
        o_sr_load = 1'b0;
        o_sr_en   = 1'b0;
        o_sclk    = 1'b0;
        o_latch   = 1'b0;
        case (state_q)
            S_LOAD:  o_sr_load = ~i_abort;
            S_HIGH:  o_sclk    = 1'b1;
            S_SHIFT: o_sr_en   = ~i_sr_done & ~i_abort;
            S_LATCH: o_latch   = 1'b1;
            S_DONE:  o_done    = 1'b1;
            default: ;
        endcase
    end

    assign o_word_addr = idx_q;
    assign o_sr_value  = i_word;

endmodule
`default_nettype wire

// File: tb/tb_sr_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_sr_stream_sequencer
// Brief  : Scoreboard bench for sr_stream_sequencer + shift_register, in a
//          two-word configuration and a single-word CLK_DIV=1 configuration.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sr_stream_sequencer;

    localparam int NB   = 8;
    localparam int NW   = 2;
    localparam int CD   = 2;
    localparam int NW_E = 1;
    localparam int CD_E = 1;
    localparam int LAT   = NW   * (2 + NB * (2 * CD   + 1)) + CD   + 1;
    localparam int LAT_E = NW_E * (2 + NB * (2 * CD_E + 1)) + CD_E + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start, abort, busy, done, load, en, sdone, sclk, latch, sdata;
    logic [0:0]    addr;
    logic [NB-1:0] word, value;
    logic [NB-1:0] bank [NW];

    logic          start_e, abort_e, busy_e, done_e, load_e, en_e, sdone_e, sclk_e, latch_e, sdata_e;
    logic [0:0]    addr_e;
    logic [NB-1:0] word_e, value_e, bank_e;

    always @(posedge clk) word   <= bank[addr];
    always @(posedge clk) word_e <= bank_e;

    sr_stream_sequencer #(.NB_REG(NB), .N_WORDS(NW), .CLK_DIV(CD)) u_seq (
        .clk(clk), .rst(rst), .i_start(start), .i_abort(abort), .o_busy(busy),
        .o_done(done), .o_word_addr(addr), .i_word(word), .o_sr_load(load),
        .o_sr_en(en), .o_sr_value(value), .i_sr_done(sdone), .o_sclk(sclk),
        .o_latch(latch)
    );
    shift_register #(.NB_REG(NB)) u_sr (
        .clk(clk), .rst(rst), .i_load(load), .i_en(en), .i_value(value),
        .o_data(sdata), .o_done(sdone)
    );

    sr_stream_sequencer #(.NB_REG(NB), .N_WORDS(NW_E), .CLK_DIV(CD_E)) u_seq_e (
        .clk(clk), .rst(rst), .i_start(start_e), .i_abort(abort_e), .o_busy(busy_e),
        .o_done(done_e), .o_word_addr(addr_e), .i_word(word_e), .o_sr_load(load_e),
        .o_sr_en(en_e), .o_sr_value(value_e), .i_sr_done(sdone_e), .o_sclk(sclk_e),
        .o_latch(latch_e)
    );
    shift_register #(.NB_REG(NB)) u_sr_e (
        .clk(clk), .rst(rst), .i_load(load_e), .i_en(en_e), .i_value(value_e),
        .o_data(sdata_e), .o_done(sdone_e)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboards: serial bits the sensor must see, and frames that must complete.
    bit exp_bits[$];
    int exp_lat[$];
    bit exp_bits_e[$];
    int exp_lat_e[$];
    int nbits_seen = 0;

    logic sclk_prev = 1'b0, sclk_prev_e = 1'b0;
    int busy_cnt, en_cnt, latch_cnt;
    int busy_cnt_e, en_cnt_e, latch_cnt_e;

    always @(negedge clk) begin
        if (sclk && !sclk_prev) begin
            if (exp_bits.size() == 0) check("unexpected_sclk", 1, 0);
            else                      check("serial_bit", sdata, exp_bits.pop_front());
            nbits_seen++;
        end
        sclk_prev = sclk;
        if (busy) begin
            busy_cnt++;
            en_cnt    += int'(en);
            latch_cnt += int'(latch);
        end else begin
            check("idle_outputs", {sclk, latch, en, load, done}, 0);
            busy_cnt = 0; en_cnt = 0; latch_cnt = 0;
        end
        if (done) begin
            if (exp_lat.size() == 0) check("unexpected_done", 1, 0);
            else begin
                check("frame_latency", busy_cnt, exp_lat.pop_front());
                check("en_pulses", en_cnt, NW * (NB - 1));
                check("latch_cycles", latch_cnt, CD);
                check("bits_left", exp_bits.size(), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (sclk_e && !sclk_prev_e) begin
            if (exp_bits_e.size() == 0) check("e_unexpected_sclk", 1, 0);
            else                        check("e_serial_bit", sdata_e, exp_bits_e.pop_front());
        end
        sclk_prev_e = sclk_e;
        if (busy_e) begin
            busy_cnt_e++;
            en_cnt_e    += int'(en_e);
            latch_cnt_e += int'(latch_e);
            check("e_word_addr", addr_e, 0);
        end else begin
            check("e_idle_outputs", {sclk_e, latch_e, en_e, load_e, done_e}, 0);
            busy_cnt_e = 0; en_cnt_e = 0; latch_cnt_e = 0;
        end
        if (done_e) begin
            if (exp_lat_e.size() == 0) check("e_unexpected_done", 1, 0);
            else begin
                check("e_frame_latency", busy_cnt_e, exp_lat_e.pop_front());
                check("e_en_pulses", en_cnt_e, NW_E * (NB - 1));
                check("e_latch_cycles", latch_cnt_e, CD_E);
                check("e_bits_left", exp_bits_e.size(), 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_frame(input logic [NB-1:0] w0, input logic [NB-1:0] w1, input bit exp_done);
        bank[0] = w0;
        bank[1] = w1;
        for (int b = NB - 1; b >= 0; b--) exp_bits.push_back(w0[b]);
        for (int b = NB - 1; b >= 0; b--) exp_bits.push_back(w1[b]);
        if (exp_done) exp_lat.push_back(LAT);
    endtask

    task automatic push_frame_e(input logic [NB-1:0] w);
        bank_e = w;
        for (int b = NB - 1; b >= 0; b--) exp_bits_e.push_back(w[b]);
        exp_lat_e.push_back(LAT_E);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (busy && n < maxc) begin
            tick(1);
            n++;
        end
        check("frame_timeout", busy, 0);
    endtask

    task automatic wait_idle_e(input int maxc);
        int n = 0;
        while (busy_e && n < maxc) begin
            tick(1);
            n++;
        end
        check("e_frame_timeout", busy_e, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        start = 0; abort = 0; start_e = 0; abort_e = 0; rst = 1'b1;
        bank[0] = '0; bank[1] = '0; bank_e = '0;

        tick(3);
        check("reset_outputs", {busy, done, load, en, sclk, latch, addr}, 0);
        check("e_reset_outputs", {busy_e, done_e, load_e, en_e, sclk_e, latch_e, addr_e}, 0);
        rst = 1'b0;
        tick(2);

        push_frame(8'hA5, 8'h3C, 1'b1);
        pulse_start();
        wait_idle(LAT + 20);
        tick(3);

        // Abort after the fourth serial bit of word 0 has been sampled.
        push_frame(8'hC3, 8'h96, 1'b0);
        base = nbits_seen;
        pulse_start();
        n = 0;
        while (nbits_seen < base + 4 && n < 200) begin
            tick(1);
            n++;
        end
        check("abort_reached_bit3", int'(nbits_seen >= base + 4), 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        exp_bits.delete();
        check("abort_busy", busy, 0);
        check("abort_sclk", {sclk, latch}, 0);
        tick(3);

        push_frame(8'h5A, 8'hF0, 1'b1);
        pulse_start();
        wait_idle(LAT + 20);
        tick(2);

        start = 1'b1; abort = 1'b1;
        tick(1);
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", busy, 0);
        tick(1);
        check("start_abort_busy_later", busy, 0);

        for (int f = 0; f < 3; f++) begin
            push_frame(NB'($urandom), NB'($urandom), 1'b1);
            pulse_start();
            for (int k = 0; k < 4; k++) begin
                tick($urandom_range(3, 15));
                start = 1'b1;
                tick(1);
                start = 1'b0;
            end
            wait_idle(LAT + 20);
            tick($urandom_range(1, 4));
        end

        push_frame(NB'($urandom), NB'($urandom), 1'b0);
        pulse_start();
        tick($urandom_range(10, 80));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_bits.delete();
        check("midframe_rst_busy", busy, 0);
        check("midframe_rst_sclk", {sclk, latch}, 0);
        tick(3);

        push_frame_e(8'h80);
        start_e = 1'b1;
        tick(1);
        start_e = 1'b0;
        wait_idle_e(LAT_E + 20);
        for (int f = 0; f < 2; f++) begin
            tick(2);
            push_frame_e(NB'($urandom));
            start_e = 1'b1;
            tick(1);
            start_e = 1'b0;
            wait_idle_e(LAT_E + 20);
        end

        tick(5);
        check("pending_bits", exp_bits.size(), 0);
        check("pending_frames", exp_lat.size(), 0);
        check("e_pending_bits", exp_bits_e.size(), 0);
        check("e_pending_frames", exp_lat_e.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
